// File: rtl/csa_sched_pkg.sv
// rtl/csa_sched_pkg.sv - state encoding, slice width and resolve sizing for csa_accum_sched
package csa_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    OUT     = 2'd3
  } state_t;

  localparam int SLICE_W = 4;

  // Number of carry-propagate cycles needed to resolve a w-bit redundant value.
  function automatic int resolve_cycles(input int w);
    return (w + SLICE_W - 1) / SLICE_W;
  endfunction

endpackage

// File: rtl/csa_resolve_slice4.sv
// rtl/csa_resolve_slice4.sv - 4-bit carry-propagate adder slice reused across resolve cycles
module csa_resolve_slice4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

endmodule

// File: rtl/csa_accum_sched.sv
// rtl/csa_accum_sched.sv - carry-save accumulation sequencer; CSA_OVF_EN adds guard bits and res_ovf
module csa_accum_sched
  import csa_sched_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [WIDTH-1:0] op_data,
  input  logic             op_last,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic [CNT_W-1:0] res_count
`ifdef CSA_OVF_EN
  ,
  output logic             res_ovf
`endif
);

  // Internal redundant width: guard bits above WIDTH let overflow be observed.
`ifdef CSA_OVF_EN
  localparam int IW = WIDTH + CNT_W;
`else
  localparam int IW = WIDTH;
`endif
  localparam int NCH   = resolve_cycles(IW);
  localparam int PW    = NCH * SLICE_W;
  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state;
  state_t           state_nxt;
  logic [IW-1:0]    sum_r;
  logic [IW-1:0]    carry_r;
  logic [IW-1:0]    cs;
  logic [IW-1:0]    op_ext;
  logic [PW-1:0]    res_r;
  logic [PW-1:0]    sum_p;
  logic [PW-1:0]    cs_p;
  logic [CNT_W-1:0] cnt_r;
  logic [IDX_W-1:0] idx_r;
  logic             c_r;
  logic             accept;
  logic             last_chunk;
  logic [31:0]      base;
  logic [3:0]       slice_a;
  logic [3:0]       slice_b;
  logic [3:0]       slice_s;
  logic             slice_co;

`ifdef CSA_OVF_EN
  assign op_ext = {{CNT_W{1'b0}}, op_data};
`else
  assign op_ext = op_data;
`endif

  // Operands are only taken while folding; ready is forced low while reset is asserted.
  assign op_ready   = !rst && ((state == IDLE) || (state == ACCUM));
  assign accept     = op_valid && op_ready;
  assign cs         = carry_r << 1;
  assign last_chunk = (idx_r == IDX_W'(NCH - 1));
  assign base       = 32'(idx_r) * SLICE_W;

  // Zero-pad the redundant pair up to a whole number of slices.
  always_comb begin
    sum_p = '0;
    cs_p  = '0;
    sum_p[IW-1:0] = sum_r;
    cs_p[IW-1:0]  = cs;
  end

  assign slice_a = sum_p[base +: SLICE_W];
  assign slice_b = cs_p[base +: SLICE_W];

  csa_resolve_slice4 u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (c_r),
    .sum  (slice_s),
    .cout (slice_co)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state selection.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = op_last ? RESOLVE : ACCUM;
      ACCUM:   if (accept && op_last) state_nxt = RESOLVE;
      RESOLVE: if (last_chunk) state_nxt = OUT;
      OUT:     if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: fold operands into sum/carry, then ripple-resolve one slice per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_r   <= '0;
      carry_r <= '0;
      cnt_r   <= '0;
      idx_r   <= '0;
      c_r     <= 1'b0;
      res_r   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sum_r   <= op_ext;
            carry_r <= '0;
            cnt_r   <= CNT_W'(1);
            idx_r   <= '0;
            c_r     <= 1'b0;
          end
        end
        ACCUM: begin
          if (accept) begin
            sum_r   <= sum_r ^ cs ^ op_ext;
            carry_r <= (sum_r & cs) | (sum_r & op_ext) | (cs & op_ext);
            if (cnt_r != CNT_MAX) cnt_r <= cnt_r + CNT_W'(1);
            idx_r   <= '0;
            c_r     <= 1'b0;
          end
        end
        RESOLVE: begin
          res_r[base +: SLICE_W] <= slice_s;
          c_r   <= slice_co;
          idx_r <= idx_r + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Result is only exposed while presenting; zero otherwise.
  assign res_valid = (state == OUT);
  assign res_data  = res_valid ? res_r[WIDTH-1:0] : '0;
  assign res_count = res_valid ? cnt_r : '0;
`ifdef CSA_OVF_EN
  assign res_ovf   = res_valid && (|res_r[IW-1:WIDTH]);
`endif

endmodule
